serial_subtractor: RTL
======================

# serial_subtractor

Multi-cycle, parametrised N-bit subtractor computing D = A − B − Bin, DIGIT bits per clock, with a registered borrow chain between digits. It is the sequential successor to the single-bit full subtractor. It trades latency for area in datapaths where a full-width ripple subtractor is not wanted. A start/busy/done handshake lets a controller launch one operation at a time and read a held result. It also reports signed overflow.

## Interface
- WIDTH, 8: operand and result width in bits; ≥1.
- DIGIT, 1: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  launch request; sampled only when busy=0.
- A  in  WIDTH  minuend, latched on accepted start.
- B  in  WIDTH  subtrahend, latched on accepted start.
- Bin  in  1  borrow-in, latched on accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: D/Bout/V just updated.
- D  out  WIDTH  difference, held until next completion.
- Bout  out  1  borrow out of MSB (1 ⇔ A < B + Bin, unsigned).
- V  out  1  signed (two's-complement) overflow of A − B − Bin.

## Operation
- N = WIDTH/DIGIT digit steps. States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1: latch A, B into shift registers, borrow register ← Bin, digit counter ← 0, go RUN.
- RUN: each cycle take the low DIGIT bits a, b of the shift registers. Form the (DIGIT+1)-bit value {0,a} − {0,b} − borrow. Low DIGIT bits shift into the result register from the MSB side. Borrow ← bit DIGIT of that value, i.e. 1 when a < b + borrow. Operand registers shift right by DIGIT. Counter increments. After the step with counter = N−1, go DONE.
- DONE (one cycle): done=1, busy=0. D ← result register, Bout ← borrow. V ← (A[W−1] ≠ B[W−1]) & (D[W−1] ≠ A[W−1]) using the latched operands. Next state IDLE, or RUN if start=1 this cycle (back-to-back accepted).
- start while busy=1: ignored; no queuing; latched operands unchanged.
- Input changes on A/B/Bin after acceptance have no effect on the running operation.
- D, Bout, V change only on the DONE transition and are otherwise held.
- Reset: state IDLE, busy=0, done=0, D=0, Bout=0, V=0, counter=0, borrow=0. Reset wins over start on the same edge. Reset mid-RUN aborts; no done pulse; outputs read 0.
- WIDTH=DIGIT=1 degenerates to a registered full subtractor (N=1).

## Timing
- Start accepted at edge k (start=1, busy=0). busy=1 for cycles after edges k … k+N−1 (exactly N cycles).
- done=1 and new D/Bout/V visible in the cycle after edge k+N. Latency is N+1 cycles from start sample to done.
- Throughput: one result per N+1 cycles with start held high or asserted during the DONE cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- done never coincides with busy=1.

## Test plan
- WIDTH=1, DIGIT=1, all 8 (A,B,Bin) combinations → D/Bout match the full-subtractor truth table: 000→0/0, 001→1/1, 010→1/1, 011→0/1, 100→1/0, 101→0/0, 110→0/0, 111→1/1. done appears 2 cycles after start.
- WIDTH=8, DIGIT=1 arithmetic:
  - A=0x05, B=0x03, Bin=0 → D=0x02, Bout=0, V=0; busy high 8 cycles, done on 9th.
  - A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1, V=0.
  - A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1.
- WIDTH=8, signed overflow:
  - A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, V=1.
  - A=0x7F, B=0xFF → D=0x80, Bout=1, V=1.
- WIDTH=8, DIGIT=4: A=0x10, B=0x01, Bin=0 → D=0x0F, Bout=0; busy exactly 2 cycles, done 3 cycles after start. Random 1000-vector sweep against a golden model for WIDTH=16 with DIGIT ∈ {1, 2, 4, 16}.
- Handshake: start pulsed again mid-RUN with different A/B → ignored, first result correct. start asserted in the DONE cycle → second operation begins; D holds the first result until the second done.
- Reset mid-RUN (after 3 of 8 steps) → next cycle busy=0, done=0, D=0, Bout=0, V=0, no done pulse. Fresh start then completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin, DIGIT bits per clock, with a registered borrow
// chain, start/busy/done handshake and signed-overflow flag.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              amsb_q, amsb_d;
  logic              bmsb_q, bmsb_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              bout_q, bout_d;
  logic              v_q, v_d;

  logic [DIGIT:0]    diff;
  logic [WIDTH-1:0]  a_shift;

  assign diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};

  // The minuend register doubles as the result register: difference digits enter at the MSB
  // end as consumed minuend digits leave at the LSB end.
  assign a_shift = (a_q >> DIGIT) | (WIDTH'(diff[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    d_d      = d_q;
    bout_d   = bout_q;
    v_d      = v_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d  = StRun;
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          cnt_d    = '0;
          amsb_d   = A[WIDTH-1];
          bmsb_d   = B[WIDTH-1];
        end
      end
      StRun: begin
        a_d      = a_shift;
        b_d      = b_q >> DIGIT;
        borrow_d = diff[DIGIT];
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          // Results are committed on entry to StDone so they appear together with done.
          state_d = StDone;
          d_d     = a_shift;
          bout_d  = diff[DIGIT];
          v_d     = (amsb_q ^ bmsb_q) & (a_shift[WIDTH-1] ^ amsb_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule
